// File: rtl/raisin64_mem_pkg.sv
// raisin64_mem_pkg: shared state type, port IDs and word geometry for the test-RAM arbiter.
package raisin64_mem_pkg;

    localparam int unsigned WORD_BYTES = 8;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_t;

    // Highest legal start address: the whole 8-byte word must fit inside the RAM.
    function automatic logic [63:0] last_word_addr(input int unsigned ram_bytes);
        return 64'(ram_bytes - WORD_BYTES);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational I/D winner selection for mem_arbiter.
// MEM_ARB_RR_EN selects round-robin via `prio`; otherwise D has fixed priority over I.
module mem_arb_pick
    import raisin64_mem_pkg::*;
(
    input  logic elig_i,
    input  logic elig_d,
`ifdef MEM_ARB_RR_EN
    input  logic prio,
`endif
    output logic gnt_valid,
    output logic gnt_port
);

    always_comb begin
        gnt_valid = elig_i | elig_d;
        gnt_port  = PORT_D;
`ifdef MEM_ARB_RR_EN
        // prio names the port favoured on a tie, i.e. the one not granted last.
        if (elig_i && elig_d) begin
            gnt_port = prio;
        end else if (elig_i) begin
            gnt_port = PORT_I;
        end
`else
        if (elig_i && !elig_d) begin
            gnt_port = PORT_I;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port 64-bit test RAM between the I-fetch and D load/store ports.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default build uses fixed D-over-I priority.
module mem_arbiter
    import raisin64_mem_pkg::*;
#(
    parameter int unsigned RAM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [63:0] i_addr,
    output logic        i_ack,
    output logic [63:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ack,
    output logic [63:0] d_rdata,
    output logic        d_err,
    output logic        ram_cs,
    output logic        ram_we,
    output logic [63:0] ram_addr,
    output logic [63:0] ram_wdata,
    input  logic [63:0] ram_rdata
);

    localparam logic [63:0] ADDR_LIMIT = last_word_addr(RAM_BYTES);

    arb_state_t  state;
    arb_state_t  state_next;

    logic        grant_q;
    logic        we_q;
    logic        err_q;
    logic        from_resp_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;

    logic        elig_i;
    logic        elig_d;
    logic        pick_valid;
    logic        pick_port;
    logic        req_we;
    logic        req_ok;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    // The port acked in the previous cycle still shows its falling req, so skip it once.
    always_comb begin
        elig_i    = i_req && !(from_resp_q && (grant_q == PORT_I));
        elig_d    = d_req && !(from_resp_q && (grant_q == PORT_D));
        req_addr  = (pick_port == PORT_D) ? d_addr : i_addr;
        req_wdata = (pick_port == PORT_D) ? d_wdata : '0;
        req_we    = (pick_port == PORT_D) && d_we;
        req_ok    = (req_addr <= ADDR_LIMIT);
    end

`ifdef MEM_ARB_RR_EN
    logic prio_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= PORT_D;
        end else if (state == IDLE && pick_valid) begin
            prio_q <= ~pick_port;
        end
    end

    mem_arb_pick u_pick (
        .elig_i    (elig_i),
        .elig_d    (elig_d),
        .prio      (prio_q),
        .gnt_valid (pick_valid),
        .gnt_port  (pick_port)
    );
`else
    mem_arb_pick u_pick (
        .elig_i    (elig_i),
        .elig_d    (elig_d),
        .gnt_valid (pick_valid),
        .gnt_port  (pick_port)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = req_ok ? ISSUE : RESP;
                end
            end
            ISSUE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q     <= PORT_D;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            from_resp_q <= 1'b0;
        end else begin
            from_resp_q <= (state == RESP);
            if (state == IDLE && pick_valid) begin
                grant_q <= pick_port;
                we_q    <= req_we;
                err_q   <= !req_ok;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // Outputs decode the state register directly so reset drops ram_cs without waiting for a clock.
    always_comb begin
        ram_cs  = (state == ISSUE);
        ram_we  = (state == ISSUE) && we_q;
        i_ack   = (state == RESP) && (grant_q == PORT_I);
        d_ack   = (state == RESP) && (grant_q == PORT_D);
        i_err   = i_ack && err_q;
        d_err   = d_ack && err_q;
        i_rdata = (i_ack && !err_q) ? ram_rdata : '0;
        d_rdata = (d_ack && !err_q && !we_q) ? ram_rdata : '0;
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter with a byte-level reference memory.
module tb_mem_arbiter;

    localparam int unsigned RAM_BYTES = 4096;
    localparam logic [63:0] LIMIT = 64'(RAM_BYTES - 8);
    localparam logic P_I = 1'b0;
    localparam logic P_D = 1'b1;

    logic        clk;
    logic        rst;
    logic        i_req, i_ack, i_err;
    logic [63:0] i_addr, i_rdata;
    logic        d_req, d_we, d_ack, d_err;
    logic [63:0] d_addr, d_wdata, d_rdata;
    logic        ram_cs, ram_we;
    logic [63:0] ram_addr, ram_wdata, ram_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic model_last;

    logic [7:0] ram_mem [RAM_BYTES];
    logic [7:0] ref_mem [RAM_BYTES];

    mem_arbiter #(.RAM_BYTES(RAM_BYTES)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Test RAM: registered read, big-endian byte order within the word.
    always @(posedge clk) begin
        if (ram_cs) begin
            logic [63:0] word;
            for (int k = 0; k < 8; k++) begin
                int unsigned idx;
                idx = (int'(ram_addr[11:0]) + k) % RAM_BYTES;
                word[63-8*k -: 8] = ram_mem[idx];
                if (ram_we) ram_mem[idx] <= ram_wdata[63-8*k -: 8];
            end
            ram_rdata <= word;
        end
    end

    function automatic logic in_range(input logic [63:0] a);
        return a <= LIMIT;
    endfunction

    function automatic logic [63:0] ref_read(input logic [63:0] a);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[63-8*k -: 8] = ref_mem[int'(a[11:0]) + k];
        return w;
    endfunction

    function automatic void ref_write(input logic [63:0] a, input logic [63:0] w);
        for (int k = 0; k < 8; k++) ref_mem[int'(a[11:0]) + k] = w[63-8*k -: 8];
    endfunction

    // Winner when both ports are eligible at once.
    function automatic logic policy_pick();
`ifdef MEM_ARB_RR_EN
        return (model_last == P_D) ? P_I : P_D;
`else
        return P_D;
`endif
    endfunction

    function automatic logic [63:0] rand_addr();
        int unsigned sel;
        logic [63:0] a;
        sel = $urandom_range(0, 9);
        case (sel)
            0: a = LIMIT;
            1: a = LIMIT + 64'($urandom_range(1, 7));
            2: a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
            3: a = 64'hFFFF_FFFF_FFFF_FFF8;
            4: a = {32'h1, 32'($urandom_range(0, 64))};
            default: a = 64'($urandom_range(0, 128));
        endcase
        return a;
    endfunction

    // Drives one transaction on a port and waits (bounded) for its ack; lat=0 means no ack came.
    task automatic txn(input logic port, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, output logic [63:0] rdata, output logic err,
                       output int lat, output int cs_cnt, output int we_cnt,
                       output logic [63:0] cs_addr, output logic [63:0] cs_wdata);
        if (port == P_D) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        lat = 0; cs_cnt = 0; we_cnt = 0; rdata = '0; err = 1'b0;
        cs_addr = '0; cs_wdata = '0;
        for (int c = 1; c <= 16 && lat == 0; c++) begin
            @(negedge clk);
            if (ram_cs) begin
                cs_cnt++;
                cs_addr = ram_addr;
                cs_wdata = ram_wdata;
            end
            if (ram_cs && ram_we) we_cnt++;
            if ((port == P_D) ? d_ack : i_ack) begin
                lat   = c;
                rdata = (port == P_D) ? d_rdata : i_rdata;
                err   = (port == P_D) ? d_err : i_err;
            end
        end
        if (port == P_D) d_req = 1'b0; else i_req = 1'b0;
        model_last = port;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int pass = 0; pass < 2; pass++) begin
            n_checks++;
            if ({i_ack, i_err, d_ack, d_err, ram_cs, ram_we} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_flags[%0d]: got %b required 000000", pass,
                         {i_ack, i_err, d_ack, d_err, ram_cs, ram_we});
            end
            n_checks++;
            if ((i_rdata | d_rdata | ram_addr | ram_wdata) !== 64'h0) begin
                n_fail++;
                $display("FAIL reset_buses[%0d]: got i_rdata=%h d_rdata=%h ram_addr=%h ram_wdata=%h required all 0",
                         pass, i_rdata, d_rdata, ram_addr, ram_wdata);
            end
            rst = 1'b0;
            @(negedge clk);
        end
        model_last = P_I;
    endtask

    task automatic test_simultaneous();
        logic win;
        int i_cyc, d_cyc;
        logic [63:0] i_got, d_got, i_exp, d_exp;
        win = policy_pick();
        i_cyc = 0; d_cyc = 0; i_got = '0; d_got = '0;
        i_exp = ref_read(64'h10);
        d_exp = ref_read(64'h28);
        i_req = 1'b1; i_addr = 64'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h28; d_wdata = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (d_ack) begin d_cyc = c; d_got = d_rdata; d_req = 1'b0; end
            if (i_ack) begin i_cyc = c; i_got = i_rdata; i_req = 1'b0; end
        end
        i_req = 1'b0; d_req = 1'b0;
        model_last = ~win;
        n_checks++;
        if (d_cyc !== ((win == P_D) ? 2 : 5)) begin
            n_fail++;
            $display("FAIL simul_d_ack_cycle: got %0d required %0d", d_cyc, (win == P_D) ? 2 : 5);
        end
        n_checks++;
        if (i_cyc !== ((win == P_I) ? 2 : 5)) begin
            n_fail++;
            $display("FAIL simul_i_ack_cycle: got %0d required %0d", i_cyc, (win == P_I) ? 2 : 5);
        end
        n_checks++;
        if (i_got !== i_exp || d_got !== d_exp) begin
            n_fail++;
            $display("FAIL simul_data: got i=%h d=%h required i=%h d=%h", i_got, d_got, i_exp, d_exp);
        end
    endtask

    task automatic test_store_load();
        logic [63:0] rd, ca, cw;
        logic er;
        int lat, csn, wen;
        txn(P_D, 1'b1, 64'h10, 64'h0123_4567_89AB_CDEF, rd, er, lat, csn, wen, ca, cw);
        ref_write(64'h10, 64'h0123_4567_89AB_CDEF);
        n_checks++;
        if (lat !== 2 || csn !== 1 || wen !== 1) begin
            n_fail++;
            $display("FAIL store_timing: got lat=%0d cs=%0d we=%0d required lat=2 cs=1 we=1", lat, csn, wen);
        end
        n_checks++;
        if (ca !== 64'h10 || cw !== 64'h0123_4567_89AB_CDEF) begin
            n_fail++;
            $display("FAIL store_bus: got addr=%h wdata=%h required addr=10 wdata=0123456789abcdef", ca, cw);
        end
        n_checks++;
        if (rd !== 64'h0 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL store_resp: got rdata=%h err=%b required 0/0", rd, er);
        end
        txn(P_D, 1'b0, 64'h10, 64'h0, rd, er, lat, csn, wen, ca, cw);
        n_checks++;
        if (rd !== 64'h0123_4567_89AB_CDEF || er !== 1'b0 || lat !== 2 || wen !== 0) begin
            n_fail++;
            $display("FAIL load_back: got rdata=%h err=%b lat=%0d we=%0d required 0123456789abcdef/0/2/0",
                     rd, er, lat, wen);
        end
        txn(P_I, 1'b0, 64'h13, 64'h0, rd, er, lat, csn, wen, ca, cw);
        n_checks++;
        if (rd !== ref_read(64'h13) || er !== 1'b0 || lat !== 2 || ca !== 64'h13) begin
            n_fail++;
            $display("FAIL fetch_unaligned: got rdata=%h err=%b lat=%0d addr=%h required %h/0/2/13",
                     rd, er, lat, ca, ref_read(64'h13));
        end
    endtask

    task automatic test_boundary();
        logic [63:0] rd, ca, cw, wd;
        logic [63:0] bad [4];
        logic er;
        int lat, csn, wen;
        wd = {$urandom, $urandom};
        txn(P_D, 1'b1, LIMIT, wd, rd, er, lat, csn, wen, ca, cw);
        ref_write(LIMIT, wd);
        n_checks++;
        if (er !== 1'b0 || lat !== 2 || csn !== 1 || ca !== LIMIT) begin
            n_fail++;
            $display("FAIL edge_store: got err=%b lat=%0d cs=%0d addr=%h required 0/2/1/%h", er, lat, csn, ca, LIMIT);
        end
        txn(P_I, 1'b0, LIMIT, 64'h0, rd, er, lat, csn, wen, ca, cw);
        n_checks++;
        if (rd !== wd || er !== 1'b0 || lat !== 2) begin
            n_fail++;
            $display("FAIL edge_fetch: got rdata=%h err=%b lat=%0d required %h/0/2", rd, er, lat, wd);
        end
        bad[0] = LIMIT + 64'd1;
        bad[1] = 64'hFFFF_FFFF_FFFF_FFF8;
        bad[2] = 64'h0000_0001_0000_0010;
        bad[3] = 64'(RAM_BYTES - 1);
        for (int b = 0; b < 4; b++) begin
            for (int p = 0; p < 2; p++) begin
                txn(p[0], p[0], bad[b], 64'hDEAD_BEEF_0000_0001, rd, er, lat, csn, wen, ca, cw);
                n_checks++;
                if (er !== 1'b1 || lat !== 1 || csn !== 0 || rd !== 64'h0) begin
                    n_fail++;
                    $display("FAIL range_reject[%0d/%0d]: got err=%b lat=%0d cs=%0d rdata=%h required 1/1/0/0",
                             b, p, er, lat, csn, rd);
                end
            end
        end
    endtask

    task automatic present(input logic port, input logic we, input logic [63:0] a, input logic [63:0] w);
        if (port == P_D) begin
            d_req = 1'b1; d_we = we; d_addr = a; d_wdata = w;
        end else begin
            i_req = 1'b1; i_addr = a;
        end
    endtask

    task automatic test_contention();
        logic [63:0] t_addr [2][16];
        logic [63:0] t_wd   [2][16];
        logic        t_we   [2][16];
        int cnt [2];
        int idx [2];
        logic exp_order [$];
        int pos;
        for (int round = 0; round < 4; round++) begin
            cnt[0] = $urandom_range(3, 12);
            cnt[1] = $urandom_range(3, 12);
            for (int p = 0; p < 2; p++) begin
                idx[p] = 0;
                for (int k = 0; k < 16; k++) begin
                    t_addr[p][k] = rand_addr();
                    t_wd[p][k]   = {$urandom, $urandom};
                    t_we[p][k]   = (p == 1) && ($urandom_range(0, 1) == 1);
                end
            end
            // Both ports stay busy: first tie goes by policy, then the just-acked port always yields.
            exp_order.delete();
            begin
                int left [2];
                logic nxt;
                left[0] = cnt[0]; left[1] = cnt[1];
                nxt = policy_pick();
                while (left[0] + left[1] > 0) begin
                    if (left[nxt] == 0) nxt = ~nxt;
                    exp_order.push_back(nxt);
                    left[nxt]--;
                    nxt = ~nxt;
                end
            end
            present(P_I, 1'b0, t_addr[0][0], t_wd[0][0]);
            present(P_D, t_we[1][0], t_addr[1][0], t_wd[1][0]);
            pos = 0;
            for (int c = 0; c < 400 && pos < exp_order.size(); c++) begin
                @(negedge clk);
                n_checks++;
                if (ram_cs && !in_range(ram_addr)) begin
                    n_fail++;
                    $display("FAIL cs_out_of_range: got ram_addr=%h required <= %h", ram_addr, LIMIT);
                end
                if (!i_ack && !d_ack) begin
                    n_checks++;
                    if ((i_rdata | d_rdata) !== 64'h0 || (i_err | d_err) !== 1'b0) begin
                        n_fail++;
                        $display("FAIL idle_outputs: got i_rdata=%h d_rdata=%h errs=%b%b required zeros",
                                 i_rdata, d_rdata, i_err, d_err);
                    end
                end
                for (int pp = 1; pp >= 0; pp--) begin
                    logic ak, er;
                    logic [63:0] rd, a, exp_rd;
                    logic exp_err;
                    ak = (pp == 1) ? d_ack : i_ack;
                    rd = (pp == 1) ? d_rdata : i_rdata;
                    er = (pp == 1) ? d_err : i_err;
                    if (ak && pos < exp_order.size()) begin
                        n_checks++;
                        if (exp_order[pos] !== pp[0]) begin
                            n_fail++;
                            $display("FAIL grant_order[%0d.%0d]: got port %0d required port %0d",
                                     round, pos, pp, exp_order[pos]);
                        end
                        a = t_addr[pp][idx[pp]];
                        exp_err = !in_range(a);
                        exp_rd = (exp_err || t_we[pp][idx[pp]]) ? 64'h0 : ref_read(a);
                        if (!exp_err && t_we[pp][idx[pp]]) ref_write(a, t_wd[pp][idx[pp]]);
                        n_checks++;
                        if (rd !== exp_rd || er !== exp_err || ram_cs !== 1'b0) begin
                            n_fail++;
                            $display("FAIL txn_resp[%0d.%0d]: port %0d addr=%h got rdata=%h err=%b cs=%b required %h/%b/0",
                                     round, pos, pp, a, rd, er, ram_cs, exp_rd, exp_err);
                        end
                        pos++;
                        idx[pp]++;
                        if (idx[pp] < cnt[pp]) begin
                            present(pp[0], t_we[pp][idx[pp]], t_addr[pp][idx[pp]], t_wd[pp][idx[pp]]);
                        end else if (pp == 1) begin
                            d_req = 1'b0;
                        end else begin
                            i_req = 1'b0;
                        end
                    end
                end
            end
            n_checks++;
            if (pos !== exp_order.size()) begin
                n_fail++;
                $display("FAIL contention_done[%0d]: got %0d acks required %0d", round, pos, exp_order.size());
            end
            i_req = 1'b0; d_req = 1'b0;
            if (exp_order.size() > 0) model_last = exp_order[exp_order.size() - 1];
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] rd, ca, cw;
        logic er;
        int lat, csn, wen;
        logic any_ack;
        i_req = 1'b1; i_addr = 64'h20;
        @(posedge clk);
        #2;
        n_checks++;
        if (ram_cs !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_before_reset: got ram_cs=%b required 1", ram_cs);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (ram_cs !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 64'h0) begin
            n_fail++;
            $display("FAIL async_drop: got cs=%b we=%b addr=%h required 0/0/0", ram_cs, ram_we, ram_addr);
        end
        any_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            any_ack = any_ack | i_ack | d_ack;
        end
        i_req = 1'b0;
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            any_ack = any_ack | i_ack | d_ack;
        end
        n_checks++;
        if (any_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_ack: got ack=%b required 0", any_ack);
        end
        model_last = P_I;
        txn(P_I, 1'b0, 64'h20, 64'h0, rd, er, lat, csn, wen, ca, cw);
        n_checks++;
        if (rd !== ref_read(64'h20) || er !== 1'b0 || lat !== 2 || csn !== 1) begin
            n_fail++;
            $display("FAIL fetch_after_reset: got rdata=%h err=%b lat=%0d cs=%0d required %h/0/2/1",
                     rd, er, lat, csn, ref_read(64'h20));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        model_last = P_I;
        for (int i = 0; i < RAM_BYTES; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            ram_mem[i] = b;
            ref_mem[i] = b;
        end
        test_reset();
        test_simultaneous();
        test_store_load();
        test_boundary();
        test_contention();
        test_async_reset();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single-port, byte-addressed 64-bit test RAM. Shares the RAM between the instruction-fetch port (I) and the data load/store port (D). Each port uses a request/acknowledge handshake. The block drives the RAM `cs`/`we`/`addr`/`data_in` pins and returns the RAM's registered `data_out`. It range-checks every access and rejects out-of-range ones before they reach the RAM.

## Interface
- `RAM_BYTES`, default 4096: RAM size in bytes. It must be ≥8 and must match the RAM instance.
- `clk` input 1: the single clock. All logic updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `i_req` input 1: I-port request. Held high until `i_ack`.
- `i_addr` input 64: I-port byte address. Stable while `i_req` is high.
- `i_ack` output 1: one-cycle completion pulse for the I port.
- `i_rdata` output 64: fetched word. Valid only while `i_ack` is high, else 0.
- `i_err` output 1: range error. Valid with `i_ack`.
- `d_req` input 1: D-port request. Held high until `d_ack`.
- `d_we` input 1: 1 = store, 0 = load. Stable with `d_req`.
- `d_addr` input 64: D-port byte address.
- `d_wdata` input 64: store data. Byte 0 at `d_addr` is bits [63:56].
- `d_ack` output 1: one-cycle completion pulse for the D port.
- `d_rdata` output 64: load word. Valid only with `d_ack`, else 0. Also 0 for stores.
- `d_err` output 1: range error. Valid with `d_ack`.
- `ram_cs`, `ram_we` output 1: RAM chip-select and write-enable.
- `ram_addr` output 64: RAM address.
- `ram_wdata` output 64: RAM write data.
- `ram_rdata` input 64: RAM `data_out`. Registered, valid the cycle after `cs`.

## Operation
- FSM states are IDLE, ISSUE and RESP. Reset enters IDLE.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - Otherwise choose a winner, latch its address/we/wdata into `ram_*` registers and record the grant.
  - If the access is in range, go to ISSUE. Otherwise latch the error and go to RESP without any RAM access.
- **Range check**: an access is legal iff `addr <= RAM_BYTES-8`. Compare all 64 bits; no truncation.
- **ISSUE**
  - Assert `ram_cs` for exactly one cycle, with `ram_we` = `d_we` for D and 0 for I.
  - Next state is RESP.
- **RESP**
  - Pulse the granted port's `ack`.
  - `rdata` = `ram_rdata` for loads and fetches; 0 for stores and errored accesses.
  - `err` is 1 only for a range-rejected access.
  - `ram_cs` and `ram_we` are 0 in this state.
  - Next state is IDLE.
- **Arbitration (default)**: D has fixed priority over I when both are pending in IDLE.
- **Simultaneous requests**: the loser keeps `req` high and is served in the next IDLE.
- **Eligibility after ack**: a port whose `ack` pulsed in RESP is not eligible in the following IDLE cycle, because its `req` is still falling. All other ports are eligible.
- **Requests not sampled**: requests are sampled only in IDLE. Changing `addr`/`wdata`/`we` or dropping `req` mid-transaction is a protocol violation. The in-flight transaction completes unchanged.
- **Unused bus values**: `ram_addr` and `ram_wdata` hold their latched values outside ISSUE. Their values are don't-care when `ram_cs`=0.

## Timing
- Request to ack is 3 cycles. `req` is sampled high in IDLE (cycle 0), ISSUE is cycle 1, and the ack pulse is in cycle 2.
- An errored access has a 2-cycle latency (IDLE→RESP).
- Throughput is one transaction per 3 cycles per RAM. A single port can issue at most one transaction every 4 cycles.
- **Reset values**:
  - All acks, errs and rdata are 0.
  - `ram_cs`, `ram_we`, `ram_addr` and `ram_wdata` are 0.
  - State is IDLE. The round-robin pointer selects D.
- **Reset mid-transaction**: `ram_cs` drops asynchronously and the transaction is discarded with no ack. A store caught in ISSUE may or may not have been written.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin arbitration. A last-granted pointer updates in IDLE whenever a grant is made.
  - On simultaneous requests, the port not granted last wins.
- `MEM_ARB_RR_EN` undefined: fixed D-over-I priority, and no pointer register exists.

## Structure
- **Package `raisin64_mem_pkg`**:
  - state enum (IDLE/ISSUE/RESP)
  - port-ID constants (`PORT_I`, `PORT_D`)
  - `WORD_BYTES` = 8
- **Sub-module `mem_arb_pick`**: combinational winner selection. It takes the eligible requests and the pointer, and returns the grant. It contains the `MEM_ARB_RR_EN` variants. The FSM stays in `mem_arbiter`.

## Test plan
- **D store then load**: D store addr 0x10, data 0x0123456789ABCDEF → `ram_cs`&`ram_we` for one cycle, `d_ack` 3 cycles after req, `d_rdata`=0. D load from 0x10 → `d_rdata`=0x0123456789ABCDEF, `d_err`=0.
- **Simultaneous requests, default build**: I and D requests raised in the same cycle → D acked at cycle 2, I acked at cycle 5, I fetch data correct.
- **Simultaneous requests, `MEM_ARB_RR_EN`**: both ports held continuously → grants alternate D, I, D, I. Without the macro → D is granted every time it is eligible, and I is granted only in IDLE cycles where D is ineligible.
- **Range boundary**: with `RAM_BYTES`=4096, addr 4088 → normal access. Addr 4089 and addr 0xFFFFFFFFFFFFFFF8 → `err`=1 at cycle 1, `ram_cs` never asserted, `rdata`=0.
- **Async reset during ISSUE**: `rst` pulsed mid-cycle while in ISSUE → `ram_cs`=0 immediately, no ack. After release, a new I fetch completes normally.
